// File: rtl/rc5_pkg.sv
// Shared RC5-32 constants, key-schedule sizing helpers and the key-expansion state encoding.
// Used by the key schedule and the encrypt/decrypt cores.
package rc5_pkg;

    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;

    localparam int ROUNDS_DEF = 12;
    localparam int T_DEF      = 2 * ROUNDS_DEF + 2;

    function automatic int t_words(input int rounds);
        return 2 * rounds + 2;
    endfunction

    function automatic int mix_count(input int t, input int c);
        return 3 * ((t > c) ? t : c);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } ks_state_t;

endpackage

// File: rtl/rc5_rotl.sv
// Purpose: 32-bit rotate-left by a 5-bit amount (amount 0 passes the input through).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module rc5_rotl (
    input  logic [31:0] din,
    input  logic [4:0]  amt,
    output logic [31:0] dout
);

    // Rotating a doubled word keeps every shift below 64 and never shifts by 32.
    logic [63:0] dbl;

    assign dbl  = {din, din} << amt;
    assign dout = dbl[63:32];

endmodule

// File: rtl/rc5_key_expand.sv
// Purpose: RC5-32 key schedule; expands the user key into round keys S[0..T-1].
// Latency: skey_vld rises T+3*max(T,KEY_WORDS) edges after the accept edge (104 by default).
// Backpressure: key_rdy low while expanding; key_vld is ignored then, never queued.
// Option: RC5_KEY_ZEROIZE_EN clears S/L on clr/accept and masks skey_out while skey_vld=0.
module rc5_key_expand
    import rc5_pkg::*;
#(
    parameter int ROUNDS    = ROUNDS_DEF,
    parameter int KEY_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [32*KEY_WORDS-1:0] din_key,
    input  logic                    key_vld,
    output logic                    key_rdy,
    output logic [64*ROUNDS+63:0]   skey_out,
    output logic                    skey_vld
);

    localparam int T  = t_words(ROUNDS);
    localparam int N  = mix_count(T, KEY_WORDS);
    localparam int IW = $clog2(T);
    localparam int JW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int CW = $clog2(N + 1);

    localparam logic [IW-1:0] I_LAST    = IW'(T - 1);
    localparam logic [JW-1:0] J_LAST    = JW'(KEY_WORDS - 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(T - 1);
    localparam logic [CW-1:0] MIX_LAST  = CW'(N - 1);

    ks_state_t     state_q, state_d;
    logic [IW-1:0] i_q;
    logic [JW-1:0] j_q;
    logic [CW-1:0] k_q;
    logic [31:0]   a_q, b_q, pq_q;

    logic [31:0]   s_q [T];
    logic [31:0]   l_q [KEY_WORDS];

    logic          accept;
    logic          init_last, mix_last;
    logic [31:0]   a_sum, a_new, ab_sum, b_sum, b_new;
    logic [IW-1:0] s_widx;

    assign accept    = key_vld && key_rdy;
    assign init_last = (k_q == INIT_LAST);
    assign mix_last  = (k_q == MIX_LAST);

    // One MIX step: both rotates settle in the same cycle.
    assign a_sum  = s_q[i_q] + a_q + b_q;
    assign ab_sum = a_new + b_q;
    assign b_sum  = l_q[j_q] + ab_sum;

    rc5_rotl u_rotl_a (
        .din  (a_sum),
        .amt  (5'd3),
        .dout (a_new)
    );

    rc5_rotl u_rotl_b (
        .din  (b_sum),
        .amt  (ab_sum[4:0]),
        .dout (b_new)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (accept)    state_d = INIT;
            INIT:       if (init_last) state_d = MIX;
            MIX:        if (mix_last)  state_d = DONE;
            default:                   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            key_rdy  <= 1'b1;
            skey_vld <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            pq_q     <= P32;
        end else begin
            state_q  <= state_d;
            key_rdy  <= (state_d == IDLE) || (state_d == DONE);
            skey_vld <= (state_d == DONE);
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        k_q  <= '0;
                        pq_q <= P32;
                    end
                end
                INIT: begin
                    pq_q <= pq_q + Q32;
                    if (init_last) begin
                        k_q <= '0;
                        i_q <= '0;
                        j_q <= '0;
                        a_q <= '0;
                        b_q <= '0;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                MIX: begin
                    a_q <= a_new;
                    b_q <= b_new;
                    i_q <= (i_q == I_LAST) ? '0 : i_q + 1'b1;
                    j_q <= (j_q == J_LAST) ? '0 : j_q + 1'b1;
                    k_q <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // S has a single write port: k addresses it during INIT, i during MIX.
    assign s_widx = (state_q == INIT) ? k_q[IW-1:0] : i_q;

    always_ff @(posedge clk) begin
        if (clr) begin
`ifdef RC5_KEY_ZEROIZE_EN
            for (int s = 0; s < T; s++) s_q[s] <= '0;
            for (int w = 0; w < KEY_WORDS; w++) l_q[w] <= '0;
`endif
        end else if (accept) begin
            for (int w = 0; w < KEY_WORDS; w++) l_q[w] <= din_key[32*w +: 32];
`ifdef RC5_KEY_ZEROIZE_EN
            for (int s = 0; s < T; s++) s_q[s] <= '0;
`endif
        end else if (state_q == INIT) begin
            s_q[s_widx] <= pq_q;
        end else if (state_q == MIX) begin
            s_q[s_widx] <= a_new;
            l_q[j_q]    <= b_new;
        end
    end

    for (genvar g = 0; g < T; g++) begin : g_out
`ifdef RC5_KEY_ZEROIZE_EN
        assign skey_out[32*g +: 32] = skey_vld ? s_q[g] : 32'h0;
`else
        assign skey_out[32*g +: 32] = s_q[g];
`endif
    end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Self-checking bench for rc5_key_expand against a software-style rc5_setup model,
// with encrypt/decrypt round trips and the published all-zero-key vector.
module tb_rc5_key_expand;

    localparam int ROUNDS = 12;
    localparam int KW     = 4;
    localparam int T      = 2 * ROUNDS + 2;
    localparam int LAT    = T + 3 * T;

    typedef logic [31:0] tab_t [T];

    logic           clk = 1'b0;
    logic           clr;
    logic [32*KW-1:0] din_key;
    logic           key_vld;
    logic           key_rdy;
    logic [32*T-1:0] skey_out;
    logic           skey_vld;

    int errors = 0;
    int checks = 0;
    int rot0_hits = 0;

    tab_t exp_s, got_s;

    rc5_key_expand #(.ROUNDS(ROUNDS), .KEY_WORDS(KW)) dut (
        .clk      (clk),
        .clr      (clr),
        .din_key  (din_key),
        .key_vld  (key_vld),
        .key_rdy  (key_rdy),
        .skey_out (skey_out),
        .skey_vld (skey_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
    endfunction

    // Textbook rc5_setup: fill S with P + k*Q, then 3*max(T,c) mixing passes.
    task automatic model_setup(input logic [127:0] key, output tab_t s);
        logic [31:0] l [KW];
        logic [31:0] a, b;
        int i, j;
        for (int w = 0; w < KW; w++) l[w] = key[32*w +: 32];
        s[0] = 32'hB7E15163;
        for (int n = 1; n < T; n++) s[n] = s[n-1] + 32'h9E3779B9;
        a = 0; b = 0; i = 0; j = 0;
        for (int n = 0; n < 3 * ((T > KW) ? T : KW); n++) begin
            a = rotl(s[i] + a + b, 5'd3);
            s[i] = a;
            if (((a + b) & 32'h1f) == 0) rot0_hits++;
            b = rotl(l[j] + a + b, 5'((a + b) & 32'h1f));
            l[j] = b;
            i = (i + 1) % T;
            j = (j + 1) % KW;
        end
    endtask

    task automatic encrypt(input tab_t s, input logic [31:0] pa, input logic [31:0] pb,
                           output logic [31:0] ca, output logic [31:0] cb);
        ca = pa + s[0];
        cb = pb + s[1];
        for (int r = 1; r <= ROUNDS; r++) begin
            ca = rotl(ca ^ cb, cb[4:0]) + s[2*r];
            cb = rotl(cb ^ ca, ca[4:0]) + s[2*r+1];
        end
    endtask

    task automatic decrypt(input tab_t s, input logic [31:0] ca, input logic [31:0] cb,
                           output logic [31:0] pa, output logic [31:0] pb);
        pa = ca;
        pb = cb;
        for (int r = ROUNDS; r >= 1; r--) begin
            pb = rotr(pb - s[2*r+1], pa[4:0]) ^ pa;
            pa = rotr(pa - s[2*r], pb[4:0]) ^ pb;
        end
        pb = pb - s[1];
        pa = pa - s[0];
    endtask

    task automatic grab();
        for (int g = 0; g < T; g++) got_s[g] = skey_out[32*g +: 32];
    endtask

    function automatic int first_diff(input tab_t x, input tab_t y);
        for (int g = 0; g < T; g++) if (x[g] !== y[g]) return g;
        return -1;
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Presents a key for one edge; returns on the negedge right after the accept edge.
    task automatic start_key(input logic [127:0] key);
        @(negedge clk);
        din_key = key;
        key_vld = 1'b1;
        @(negedge clk);
        key_vld = 1'b0;
        din_key = rand_key();
    endtask

    task automatic wait_vld(input int n0, output int n);
        n = n0;
        while (skey_vld !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        key_vld = 1'b1;
        din_key = rand_key();
        repeat (2) @(negedge clk);
        clr = 1'b0;
        key_vld = 1'b0;
        checks++;
        if (key_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_key_rdy: got %b want 1", key_rdy);
        end
        checks++;
        if (skey_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_skey_vld: got %b want 0", skey_vld);
        end
        @(negedge clk);
        checks++;
        if (key_rdy !== 1'b1 || skey_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_key_ignored: key_rdy=%b skey_vld=%b want 1/0", key_rdy, skey_vld);
        end
`ifdef RC5_KEY_ZEROIZE_EN
        checks++;
        if (skey_out !== '0) begin
            errors++;
            $display("FAIL reset_skey_out_zero: got %h", skey_out);
        end
`endif
    endtask

    task automatic test_init_latency();
        int n;
        logic [31:0] want0, want1;
`ifdef RC5_KEY_ZEROIZE_EN
        want0 = 32'h0;
        want1 = 32'h0;
`else
        want0 = 32'hB7E15163;
        want1 = 32'h5618CB1C;
`endif
        start_key(128'h0);
        checks++;
        if (key_rdy !== 1'b0 || skey_vld !== 1'b0) begin
            errors++;
            $display("FAIL accept_busy: key_rdy=%b skey_vld=%b want 0/0", key_rdy, skey_vld);
        end
        @(negedge clk);
        checks++;
        if (skey_out[31:0] !== want0) begin
            errors++;
            $display("FAIL init_s0: got %h want %h", skey_out[31:0], want0);
        end
        @(negedge clk);
        checks++;
        if (skey_out[63:32] !== want1) begin
            errors++;
            $display("FAIL init_s1: got %h want %h", skey_out[63:32], want1);
        end
        wait_vld(2, n);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL zero_key_latency: got %0d want %0d", n, LAT);
        end
    endtask

    task automatic test_rivest();
        logic [31:0] ca, cb;
        int d;
        model_setup(128'h0, exp_s);
        grab();
        d = first_diff(got_s, exp_s);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL zero_key_table: S[%0d] got %h want %h", d, got_s[d], exp_s[d]);
        end
        encrypt(got_s, 32'h0, 32'h0, ca, cb);
        checks++;
        if (ca !== 32'hEEDBA521 || cb !== 32'h6D8F4B15) begin
            errors++;
            $display("FAIL rivest_vector: got %h %h want eedba521 6d8f4b15", ca, cb);
        end
    endtask

    task automatic test_random();
        logic [127:0] key;
        logic [31:0] pa, pb, ca, cb, ra, rb;
        int n, d;
        for (int t = 0; t < 30; t++) begin
            key = rand_key();
            start_key(key);
            wait_vld(0, n);
            checks++;
            if (n != LAT) begin
                errors++;
                $display("FAIL rand_latency[%0d]: got %0d want %0d", t, n, LAT);
            end
            model_setup(key, exp_s);
            grab();
            d = first_diff(got_s, exp_s);
            checks++;
            if (d >= 0) begin
                errors++;
                $display("FAIL rand_table[%0d]: key %h S[%0d] got %h want %h", t, key, d, got_s[d], exp_s[d]);
            end
            pa = $urandom;
            pb = $urandom;
            encrypt(got_s, pa, pb, ca, cb);
            decrypt(exp_s, ca, cb, ra, rb);
            checks++;
            if (ra !== pa || rb !== pb) begin
                errors++;
                $display("FAIL rand_roundtrip[%0d]: got %h %h want %h %h", t, ra, rb, pa, pb);
            end
        end
        $display("rotate-by-0 steps seen in model: %0d", rot0_hits);
    endtask

    task automatic test_ignore_and_restart();
        logic [127:0] k1, k2;
        int n, d;
        k1 = rand_key();
        k2 = ~k1;
        start_key(k1);
        repeat (T + 40 - 1) @(negedge clk);
        din_key = k2;
        key_vld = 1'b1;
        @(negedge clk);
        key_vld = 1'b0;
        wait_vld(T + 40, n);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL busy_key_latency: got %0d want %0d", n, LAT);
        end
        model_setup(k1, exp_s);
        grab();
        d = first_diff(got_s, exp_s);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL busy_key_ignored: S[%0d] got %h want %h", d, got_s[d], exp_s[d]);
        end
        start_key(k2);
        checks++;
        if (skey_vld !== 1'b0 || key_rdy !== 1'b0) begin
            errors++;
            $display("FAIL done_restart_drop: skey_vld=%b key_rdy=%b want 0/0", skey_vld, key_rdy);
        end
        wait_vld(0, n);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL done_restart_latency: got %0d want %0d", n, LAT);
        end
        model_setup(k2, exp_s);
        grab();
        d = first_diff(got_s, exp_s);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL done_restart_table: S[%0d] got %h want %h", d, got_s[d], exp_s[d]);
        end
    endtask

    task automatic test_clr_abort();
        logic [127:0] k;
        int n, d;
        start_key(rand_key());
        repeat (10) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (skey_vld !== 1'b0 || key_rdy !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: skey_vld=%b key_rdy=%b want 0/1", skey_vld, key_rdy);
        end
`ifdef RC5_KEY_ZEROIZE_EN
        checks++;
        if (skey_out !== '0) begin
            errors++;
            $display("FAIL abort_zeroize: got %h", skey_out);
        end
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (key_rdy !== 1'b1 || skey_vld !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle: key_rdy=%b skey_vld=%b want 1/0", key_rdy, skey_vld);
        end
        k = rand_key();
        start_key(k);
        wait_vld(0, n);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL abort_next_latency: got %0d want %0d", n, LAT);
        end
        model_setup(k, exp_s);
        grab();
        d = first_diff(got_s, exp_s);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL abort_next_table: S[%0d] got %h want %h", d, got_s[d], exp_s[d]);
        end
    endtask

    initial begin
        clr = 1'b1;
        key_vld = 1'b0;
        din_key = '0;
        test_reset();
        test_init_latency();
        test_rivest();
        test_random();
        test_ignore_and_restart();
        test_clr_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
